// File: rtl/dbfs_log2_normalizer.sv
// dbfs_log2_normalizer
// Front end of the dBFS converter: signed PCM sample -> magnitude ->
// base-2 float (signed 6-bit exponent + left-aligned fractional mantissa).
// Three register stages (magnitude, leading-one detect, normalize) under one
// global stall. Bubbles travel with the data so latency stays fixed at 3.
// DATA_WIDTH is limited to 2..32 so the exponent fits 6 bits.
module dbfs_log2_normalizer #(
   parameter int DATA_WIDTH = 24,
   parameter int MANT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [5:0]            m_exp,
   output logic [MANT_WIDTH-1:0] m_mant,
   output logic                  m_zero
);

   // Magnitude keeps one bit less than the sample: the most negative code
   // saturates instead of needing an extra bit.
   localparam int MAG_W = DATA_WIDTH - 1;
   localparam int IDX_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;

   localparam logic [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {MAG_W{1'b0}}};
   localparam logic [MAG_W-1:0]      MAG_SAT   = {MAG_W{1'b1}};
   localparam logic [5:0]            ZERO_EXP  = 6'b100000;
   localparam logic [5:0]            EXP_BIAS  = 6'(DATA_WIDTH - 1);

   // ---------------------------------------------------------------------
   // Stage registers
   // ---------------------------------------------------------------------
   logic             s1_vld_q, s1_vld_d;
   logic [MAG_W-1:0] s1_mag_q, s1_mag_d;

   logic             s2_vld_q, s2_vld_d;
   logic [MAG_W-1:0] s2_mag_q, s2_mag_d;
   logic [4:0]       s2_p_q, s2_p_d;
   logic             s2_zero_q, s2_zero_d;

   logic                  s3_vld_q, s3_vld_d;
   logic [5:0]            s3_exp_q, s3_exp_d;
   logic [MANT_WIDTH-1:0] s3_mant_q, s3_mant_d;
   logic                  s3_zero_q, s3_zero_d;

   logic advance;

   // Single global stall: everything moves unless the output is stuck.
   always_comb begin
      advance = !s3_vld_q || m_ready;
   end

   assign s_ready = advance;

   // ---------------------------------------------------------------------
   // S1: absolute value with saturation of the most negative code
   // ---------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] s_data_neg;

   // Compute next S1 contents: magnitude of the incoming sample.
   always_comb begin
      s_data_neg = -s_data;
      s1_vld_d   = s1_vld_q;
      s1_mag_d   = s1_mag_q;
      if (advance) begin
         s1_vld_d = s_valid;
         if (!s_data[DATA_WIDTH-1])
            s1_mag_d = s_data[MAG_W-1:0];
         else if (s_data == MOST_NEG)
            s1_mag_d = MAG_SAT;
         else
            s1_mag_d = s_data_neg[MAG_W-1:0];
      end
   end

   // ---------------------------------------------------------------------
   // S2: leading-one detect (priority encoder, highest set bit wins)
   // ---------------------------------------------------------------------
   logic [4:0] lod_p;
   logic       lod_zero;

   // Priority-encode the S1 magnitude; ascending scan so the top one sticks.
   always_comb begin
      lod_p    = '0;
      lod_zero = 1'b1;
      for (int i = 0; i < MAG_W; i++) begin
         if (s1_mag_q[i]) begin
            lod_p    = 5'(i);
            lod_zero = 1'b0;
         end
      end
   end

   // Compute next S2 contents: forward magnitude alongside its leading-one index.
   always_comb begin
      s2_vld_d  = s2_vld_q;
      s2_mag_d  = s2_mag_q;
      s2_p_d    = s2_p_q;
      s2_zero_d = s2_zero_q;
      if (advance) begin
         s2_vld_d  = s1_vld_q;
         s2_mag_d  = s1_mag_q;
         s2_p_d    = lod_p;
         s2_zero_d = lod_zero;
      end
   end

   // ---------------------------------------------------------------------
   // S3: normalize
   // Mantissa bit k (from the MSB) is magnitude bit p-1-k, i.e. the
   // magnitude shifted so the leading one sits just above the mantissa,
   // leading one dropped, truncated, zero-filled below bit 0.
   // ---------------------------------------------------------------------
   logic [MANT_WIDTH-1:0] norm_mant;
   logic [5:0]            norm_exp;
   int                    p_int;

   // Barrel-normalize the S2 magnitude and form the unbiased exponent.
   always_comb begin
      p_int     = int'(s2_p_q);
      norm_mant = '0;
      for (int k = 0; k < MANT_WIDTH; k++) begin
         if (k < p_int)
            norm_mant[MANT_WIDTH-1-k] = s2_mag_q[IDX_W'(p_int - 1 - k)];
      end
      norm_exp = {1'b0, s2_p_q} - EXP_BIAS;
      // A zero magnitude gets the floor code; downstream keys off m_zero.
      if (s2_zero_q) begin
         norm_mant = '0;
         norm_exp  = ZERO_EXP;
      end
   end

   // Compute next S3 contents: the registered output word.
   always_comb begin
      s3_vld_d  = s3_vld_q;
      s3_exp_d  = s3_exp_q;
      s3_mant_d = s3_mant_q;
      s3_zero_d = s3_zero_q;
      if (advance) begin
         s3_vld_d  = s2_vld_q;
         s3_exp_d  = norm_exp;
         s3_mant_d = norm_mant;
         s3_zero_d = s2_zero_q;
      end
   end

   // All pipeline state; synchronous reset flushes every in-flight sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld_q  <= 1'b0;
         s1_mag_q  <= '0;
         s2_vld_q  <= 1'b0;
         s2_mag_q  <= '0;
         s2_p_q    <= '0;
         s2_zero_q <= 1'b0;
         s3_vld_q  <= 1'b0;
         s3_exp_q  <= '0;
         s3_mant_q <= '0;
         s3_zero_q <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_mag_q  <= s1_mag_d;
         s2_vld_q  <= s2_vld_d;
         s2_mag_q  <= s2_mag_d;
         s2_p_q    <= s2_p_d;
         s2_zero_q <= s2_zero_d;
         s3_vld_q  <= s3_vld_d;
         s3_exp_q  <= s3_exp_d;
         s3_mant_q <= s3_mant_d;
         s3_zero_q <= s3_zero_d;
      end
   end

   // Outputs come straight from S3 flops: no input-to-output combinational path.
   assign m_valid = s3_vld_q;
   assign m_exp   = s3_exp_q;
   assign m_mant  = s3_mant_q;
   assign m_zero  = s3_zero_q;

endmodule

// File: doc/dbfs_log2_normalizer.md
# dbfs_log2_normalizer

Upstream front end of the dBFS converter datapath. Accepts signed PCM samples over a valid/ready stream and converts each one to magnitude. It then produces a base-2 floating-point decomposition: a signed 6-bit exponent and a left-aligned fractional mantissa. The exponent drives the signed operand of the downstream exponent × (20·log10 2) multiplier. The mantissa indexes the fractional-log lookup.

## Interface

- DATA_WIDTH, 24: input sample width, two's complement; 2..32 supported (exponent must fit 6 bits).
- MANT_WIDTH, 16: output mantissa width, fraction bits below the leading one.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample this cycle.
- s_data  in  DATA_WIDTH  signed PCM sample.
- m_valid  out  1  output result valid.
- m_ready  in  1  downstream accepts the result this cycle.
- m_exp  out  6  signed exponent: p − (DATA_WIDTH−1), where p is the leading-one index of the magnitude; −32 for a zero sample.
- m_mant  out  MANT_WIDTH  magnitude bits below the leading one, MSB-aligned, truncated, zero-filled.
- m_zero  out  1  sample magnitude was zero.

## Operation

- Transfers occur when valid && ready, on either port.
- Pipeline: three register stages, S1 → S2 → S3. Each stage holds a valid bit plus data.
  - S1: magnitude. abs(s_data). −2^(DATA_WIDTH−1) saturates to 2^(DATA_WIDTH−1)−1. Magnitude is held as DATA_WIDTH−1 bits.
  - S2: leading-one detect. A priority encoder finds p ∈ [0, DATA_WIDTH−2] and sets the zero flag when the magnitude is 0. The magnitude is forwarded.
  - S3: normalize. The magnitude is shifted left by (DATA_WIDTH−2−p), the leading one is dropped, and the top MANT_WIDTH bits are taken (zero-filled if fewer remain). m_exp = p − (DATA_WIDTH−1), sign-extended to 6 bits.
- Zero sample:
  - m_zero=1, m_exp=6'b100000 (−32), m_mant=0.
  - The downstream stage treats m_zero as a floor value and must not use m_exp arithmetically.
- Nonzero range for DATA_WIDTH=24: m_exp ∈ [−23, −1].
- Flow control is a single global stall: advance = !m_valid || m_ready.
  - When advance=1, every stage loads from its predecessor, with S1 loading from the input port.
  - When advance=0, all stages hold.
  - s_ready = advance. This is combinational from m_ready and the S3 valid bit.
- Bubbles are not squeezed out. Invalid stages still shift on advance, which keeps the control simple and the latency fixed.
- m_valid, m_exp, m_mant and m_zero are driven directly from the S3 registers. No combinational path runs from s_data to any m_* output.

## Timing

- Latency: an accepted sample appears on m_* 3 cycles later, provided m_ready stayed high.
- Throughput: one sample per cycle while m_ready=1.
- Backpressure:
  - When m_valid=1 and m_ready=0, all stages freeze and s_ready=0 in the same cycle.
  - m_* outputs hold stable until m_ready=1.
- Reset, synchronous, dominating all other inputs:
  - All stage valid bits clear to 0, so m_valid=0.
  - m_exp=0, m_mant=0, m_zero=0.
  - s_ready=1 in the cycle after reset deasserts, since S3 is invalid.
- Reset mid-stream: all in-flight samples are discarded and none appear on m_*. A sample presented with s_valid in the reset cycle is not accepted.
- A simultaneous output handshake (m_valid && m_ready) and input acceptance in one cycle is legal and required for full throughput.
- s_valid=0 while advance=1 inserts a bubble: the S1 valid bit is 0.

## Test plan

- Directed values, DATA_WIDTH=24, MANT_WIDTH=16, m_ready=1:
  - 0x400000 → m_exp=−1, m_mant=0x0000.
  - 0x000001 → m_exp=−23, m_mant=0.
  - 0x000003 → m_exp=−22, m_mant=0x8000.
  - 0x7FFFFF → m_exp=−1, m_mant=0xFFFF.
  - Each result appears exactly 3 cycles after its input handshake.
- Negative and saturation:
  - 0xC00000 → m_exp=−1, m_mant=0.
  - 0x800000 → saturates, m_exp=−1, m_mant=0xFFFF.
  - 0xFFFFFF (−1) → m_exp=−23, m_mant=0.
- Zero: 0x000000 → m_zero=1, m_exp=−32, m_mant=0. The next sample, 0x000001, has m_zero=0.
- Backpressure:
  - Stream 8 back-to-back samples. Hold m_ready=0 for 5 cycles starting when the second result is valid.
  - s_ready=0 and m_* are stable throughout the stall.
  - All 8 results emerge in order with no loss or duplication.
- Reset mid-stream:
  - Assert reset for 1 cycle with 3 samples in flight.
  - m_valid=0 on the next cycle, none of the 3 samples appear, and s_ready=1 after reset.
- Randomized stream: random s_valid and m_ready, checked against a reference model of exponent, mantissa and zero flag, with order preserved.
